// File: rtl/skinny_sbox8_dom_pkg.sv
// Shared constants and helpers for the masked SKINNY-128 8-bit S-box pipeline.
//   ns(d)   share count for masking order d
//   rpg(d)  fresh random bits consumed per NOR-XOR gadget
//   ridx    index of r_ij (i<j) inside one gadget's randomness slice
//   tidx    index of cross term t_ij (i!=j) inside a gadget's cross-term register
//   BO_SRC  which a-value drives each output bit
//   GADGET_STAGE  pipeline stage (0-based) that registers each gadget
package skinny_sbox8_dom_pkg;

  localparam int STAGES  = 4;
  localparam int GADGETS = 8;

  // bo bits 7..0 come from a3,a0,a1,a6,a4,a2,a5,a7
  localparam logic [7:0][2:0] BO_SRC = {3'd3, 3'd0, 3'd1, 3'd6, 3'd4, 3'd2, 3'd5, 3'd7};

  // gadgets a0..a2 in stage 0, a3/a4 in 1, a5/a6 in 2, a7 in 3
  localparam logic [7:0][1:0] GADGET_STAGE = {2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

  function automatic int ns(input int d);
    return d + 1;
  endfunction

  function automatic int rpg(input int d);
    return d * (d + 1) / 2;
  endfunction

  // pairs enumerated (0,1),(0,2)..(0,n-1),(1,2)..
  function automatic int ridx(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

  // row i holds the n-1 terms t_ij, j skipping the diagonal
  function automatic int tidx(input int i, input int j, input int n);
    return i * (n - 1) + ((j < i) ? j : j - 1);
  endfunction

endpackage

// File: rtl/skinny_sbox8_domd_pipelined_gadget.sv
// dom_cfn_gadget: one registered DOM-independent NOR-XOR gadget,
// f = (x NOR y) XOR z over NS = D+1 Boolean shares.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         load enable (pipeline advance)
//   zero       when set together with en, load all-zero terms (bubble scrubbing)
//   x, y, z    input shares, one bit per share
//   r          fresh randomness, one bit per share pair
//   f          output shares (combinational XOR of the registered terms)
module dom_cfn_gadget
  import skinny_sbox8_dom_pkg::*;
#(
  parameter int D = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              zero,
  input  logic [ns(D)-1:0]  x,
  input  logic [ns(D)-1:0]  y,
  input  logic [ns(D)-1:0]  z,
  input  logic [rpg(D)-1:0] r,
  output logic [ns(D)-1:0]  f
);
  localparam int NS = ns(D);
  localparam int NT = NS * (NS - 1);
  // complementing one share of x and y turns the masked AND into a NOR
  localparam logic [NS-1:0] CMASK = {1'b1, {D{1'b0}}};

  logic [NS-1:0] xp, yp;
  logic [NS-1:0] g_d, g_q;
  logic [NT-1:0] t_d, t_q;

  assign xp = x ^ CMASK;
  assign yp = y ^ CMASK;

  for (genvar i = 0; i < NS; i++) begin : g_sh
    assign g_d[i] = (xp[i] & yp[i]) ^ z[i];
    for (genvar j = 0; j < NS; j++) begin : g_cr
      if (j != i) begin : g_t
        localparam int TI = tidx(i, j, NS);
        localparam int RI = (i < j) ? ridx(i, j, NS) : ridx(j, i, NS);
        // t_ij and t_ji share r_ij so the pair cancels on recombination
        assign t_d[TI] = (xp[i] & yp[j]) ^ r[RI];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q <= '0;
      t_q <= '0;
    end else if (en) begin
      if (zero) begin
        g_q <= '0;
        t_q <= '0;
      end else begin
        g_q <= g_d;
        t_q <= t_d;
      end
    end
  end

  // compression only after the registers, so no glitch crosses shares
  always_comb begin
    f = g_q;
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) begin
        if (j != i) f[i] = f[i] ^ t_q[tidx(i, j, NS)];
      end
    end
  end

endmodule

// File: rtl/skinny_sbox8_domd_pipelined.sv
// skinny_sbox8_domd_pipelined: NUM_SBOX parallel masked SKINNY-128 8-bit S-boxes,
// order-D DOM, four-stage pipeline (one gadget layer per stage), valid/ready on
// both sides with a single global advance.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake
//   si                   input shares, share s at [s*W +: W], S-box k at byte k
//   r                    fresh randomness for the beat, S-box k at k*8*RPG,
//                        gadgets a0..a7 in order, RPG bits each
//   out_valid/out_ready  output handshake
//   bo                   output shares, same packing as si
// Build option: SKINNY_SBOX8_ZEROIZE_EN makes bubble beats load all-zero shares
// and randomness, so bo is 0 whenever out_valid is 0.
module skinny_sbox8_domd_pipelined
  import skinny_sbox8_dom_pkg::*;
#(
  parameter int D        = 1,
  parameter int NUM_SBOX = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ns(D)*8*NUM_SBOX-1:0]   si,
  input  logic [8*rpg(D)*NUM_SBOX-1:0]  r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ns(D)*8*NUM_SBOX-1:0]   bo
);
  localparam int NS  = ns(D);
  localparam int W   = 8 * NUM_SBOX;
  localparam int RPG = rpg(D);

  logic              adv;
  logic [STAGES:1]   v_q;
  logic [STAGES-1:0] zero_ld;  // per stage: incoming beat is a bubble to scrub

  assign adv       = ~v_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else if (adv) v_q <= {v_q[STAGES-1:1], in_valid};
  end

`ifdef SKINNY_SBOX8_ZEROIZE_EN
  assign zero_ld = ~{v_q[STAGES-1:1], in_valid};
`else
  assign zero_ld = '0;
`endif

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    localparam int RB = k * GADGETS * RPG;

    logic [7:0][NS-1:0]       b;
    logic [GADGETS-1:0][NS-1:0] a;
    logic [GADGETS-1:0][NS-1:0] gx, gy, gz;
    logic [GADGETS-1:0][RPG-1:0] gr;
    logic [GADGETS-1:0][NS-1:0] fin;

    // carried shares, named by the value they hold
    logic [NS-1:0] s1_b7, s1_b5, s1_b3, s1_b2, s1_b1;
    logic [NS-1:0] s2_a0, s2_a1, s2_a2, s2_b7, s2_b3, s2_b2;
    logic [NS-1:0] s3_a0, s3_a1, s3_a2, s3_a3, s3_a4, s3_b2;
    logic [NS-1:0] s4_a0, s4_a1, s4_a2, s4_a3, s4_a4, s4_a5, s4_a6;

    // randomness for gadgets a3..a7, a5..a7 and a7, travelling with the beat
    logic [5*RPG-1:0] rd1;
    logic [3*RPG-1:0] rd2;
    logic [RPG-1:0]   rd3;

    // stage 1: a0, a1, a2 from input bits
    assign gx[0] = b[7];  assign gy[0] = b[6];  assign gz[0] = b[4];
    assign gx[1] = b[3];  assign gy[1] = b[2];  assign gz[1] = b[0];
    assign gx[2] = b[2];  assign gy[2] = b[1];  assign gz[2] = b[6];
    assign gr[0] = r[RB + 0*RPG +: RPG];
    assign gr[1] = r[RB + 1*RPG +: RPG];
    assign gr[2] = r[RB + 2*RPG +: RPG];

    // stage 2: a3, a4
    assign gx[3] = a[0];  assign gy[3] = a[1];  assign gz[3] = s1_b5;
    assign gx[4] = a[1];  assign gy[4] = s1_b3; assign gz[4] = s1_b1;
    assign gr[3] = rd1[0 +: RPG];
    assign gr[4] = rd1[RPG +: RPG];

    // stage 3: a5, a6
    assign gx[5] = s2_a2; assign gy[5] = a[3];  assign gz[5] = s2_b7;
    assign gx[6] = a[3];  assign gy[6] = s2_a0; assign gz[6] = s2_b3;
    assign gr[5] = rd2[0 +: RPG];
    assign gr[6] = rd2[RPG +: RPG];

    // stage 4: a7
    assign gx[7] = s3_a4; assign gy[7] = a[5];  assign gz[7] = s3_b2;
    assign gr[7] = rd3;

    for (genvar g = 0; g < GADGETS; g++) begin : g_gad
      dom_cfn_gadget #(.D(D)) u_gad (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .zero (zero_ld[GADGET_STAGE[g]]),
        .x    (gx[g]),
        .y    (gy[g]),
        .z    (gz[g]),
        .r    (gr[g]),
        .f    (a[g])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_b7 <= '0; s1_b5 <= '0; s1_b3 <= '0; s1_b2 <= '0; s1_b1 <= '0;
        rd1   <= '0;
      end else if (adv) begin
        if (zero_ld[0]) begin
          s1_b7 <= '0; s1_b5 <= '0; s1_b3 <= '0; s1_b2 <= '0; s1_b1 <= '0;
          rd1   <= '0;
        end else begin
          s1_b7 <= b[7]; s1_b5 <= b[5]; s1_b3 <= b[3]; s1_b2 <= b[2]; s1_b1 <= b[1];
          rd1   <= r[RB + 3*RPG +: 5*RPG];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_a0 <= '0; s2_a1 <= '0; s2_a2 <= '0; s2_b7 <= '0; s2_b3 <= '0; s2_b2 <= '0;
        rd2   <= '0;
      end else if (adv) begin
        if (zero_ld[1]) begin
          s2_a0 <= '0; s2_a1 <= '0; s2_a2 <= '0; s2_b7 <= '0; s2_b3 <= '0; s2_b2 <= '0;
          rd2   <= '0;
        end else begin
          s2_a0 <= a[0]; s2_a1 <= a[1]; s2_a2 <= a[2];
          s2_b7 <= s1_b7; s2_b3 <= s1_b3; s2_b2 <= s1_b2;
          rd2   <= rd1[2*RPG +: 3*RPG];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s3_a0 <= '0; s3_a1 <= '0; s3_a2 <= '0; s3_a3 <= '0; s3_a4 <= '0; s3_b2 <= '0;
        rd3   <= '0;
      end else if (adv) begin
        if (zero_ld[2]) begin
          s3_a0 <= '0; s3_a1 <= '0; s3_a2 <= '0; s3_a3 <= '0; s3_a4 <= '0; s3_b2 <= '0;
          rd3   <= '0;
        end else begin
          s3_a0 <= s2_a0; s3_a1 <= s2_a1; s3_a2 <= s2_a2;
          s3_a3 <= a[3];  s3_a4 <= a[4];  s3_b2 <= s2_b2;
          rd3   <= rd2[2*RPG +: RPG];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s4_a0 <= '0; s4_a1 <= '0; s4_a2 <= '0; s4_a3 <= '0;
        s4_a4 <= '0; s4_a5 <= '0; s4_a6 <= '0;
      end else if (adv) begin
        if (zero_ld[3]) begin
          s4_a0 <= '0; s4_a1 <= '0; s4_a2 <= '0; s4_a3 <= '0;
          s4_a4 <= '0; s4_a5 <= '0; s4_a6 <= '0;
        end else begin
          s4_a0 <= s3_a0; s4_a1 <= s3_a1; s4_a2 <= s3_a2; s4_a3 <= s3_a3;
          s4_a4 <= s3_a4; s4_a5 <= a[5];  s4_a6 <= a[6];
        end
      end
    end

    assign fin = {a[7], s4_a6, s4_a5, s4_a4, s4_a3, s4_a2, s4_a1, s4_a0};

    for (genvar s = 0; s < NS; s++) begin : g_sh
      for (genvar i = 0; i < 8; i++) begin : g_bit
        assign b[i][s]             = si[s*W + 8*k + i];
        assign bo[s*W + 8*k + i]   = fin[BO_SRC[i]][s];
      end
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_domd_pipelined.sv
module tb_skinny_sbox8_domd_pipelined;
  localparam int D        = 2;
  localparam int NUM_SBOX = 4;
  localparam int NS       = D + 1;
  localparam int W        = 8 * NUM_SBOX;
  localparam int RPG      = D * (D + 1) / 2;
  localparam int RW       = 8 * RPG * NUM_SBOX;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [NS*W-1:0] si, bo;
  logic [RW-1:0]   r;

  skinny_sbox8_domd_pipelined #(.D(D), .NUM_SBOX(NUM_SBOX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .si        (si),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bo        (bo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  bit lat_mode = 1'b0;
  logic [NS*W-1:0] last_bo;

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
    bit           lat4;
  } beat_t;
  beat_t sb[$];

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // unmasked S-box straight from the NOR-XOR network definition
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    a0 = ~(x[7] | x[6]) ^ x[4];
    a1 = ~(x[3] | x[2]) ^ x[0];
    a2 = ~(x[2] | x[1]) ^ x[6];
    a3 = ~(a0 | a1) ^ x[5];
    a4 = ~(a1 | x[3]) ^ x[1];
    a5 = ~(a2 | a3) ^ x[7];
    a6 = ~(a3 | a0) ^ x[3];
    a7 = ~(a4 | a5) ^ x[2];
    return {a3, a0, a1, a6, a4, a2, a5, a7};
  endfunction

  function automatic logic [W-1:0] sbox_word(input logic [W-1:0] v);
    logic [W-1:0] o;
    o = '0;
    for (int k = 0; k < NUM_SBOX; k++) o[8*k +: 8] = sbox_ref(v[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NS*W-1:0] share(input logic [W-1:0] v);
    logic [NS*W-1:0] s;
    logic [W-1:0]    acc;
    logic [127:0]    t;
    s   = '0;
    acc = v;
    for (int i = 0; i < NS - 1; i++) begin
      t = rnd128();
      s[i*W +: W] = t[W-1:0];
      acc = acc ^ t[W-1:0];
    end
    s[(NS-1)*W +: W] = acc;
    return s;
  endfunction

  function automatic logic [W-1:0] recombine(input logic [NS*W-1:0] x);
    logic [W-1:0] acc;
    acc = '0;
    for (int s = 0; s < NS; s++) acc = acc ^ x[s*W +: W];
    return acc;
  endfunction

  // one clock: drive at negedge, sample 1 time unit later, scoreboard the handshakes
  task automatic step(input bit iv, input logic [W-1:0] v, input bit ordy,
                      input bit use_exp, input logic [W-1:0] exp_c);
    beat_t        e;
    logic [127:0] t;
    @(negedge clk);
    in_valid  = iv;
    si        = share(v);
    t         = rnd128();
    r         = t[RW-1:0];
    out_ready = ordy;
    #1;
    chk_eq("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk_eq("spurious_out", 128'(out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk_eq("bo_value", 128'(recombine(bo)), 128'(e.exp));
        if (e.lat4) chk_eq("latency", 128'(cyc_n - e.acc), 128'(4));
        last_bo = bo;
      end
    end
`ifdef SKINNY_SBOX8_ZEROIZE_EN
    if (!out_valid) chk_eq("bo_zero_idle", 128'(bo), 128'(0));
`endif
    if (in_valid && in_ready) begin
      e.exp  = use_exp ? exp_c : sbox_word(v);
      e.acc  = cyc_n;
      e.lat4 = lat_mode;
      sb.push_back(e);
    end
    cyc_n++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    chk_eq("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [127:0] t;
    t = rnd128();
    return t[W-1:0];
  endfunction

  initial begin
    logic [W-1:0]    w;
    logic [NS*W-1:0] snap_bo, bo_a, bo_b;
    logic            snap_ov;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; si = '0; r = '0;
    last_bo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("rst_out_valid", 128'(out_valid), 128'(0));
    chk_eq("rst_in_ready",  128'(in_ready),  128'(1));
    chk_eq("rst_bo",        128'(bo),        128'(0));

    // known table entries, latency 4 each
    lat_mode = 1'b1;
    step(1'b1, {NUM_SBOX{8'h00}}, 1'b1, 1'b1, {NUM_SBOX{8'h65}});
    step(1'b1, {NUM_SBOX{8'h01}}, 1'b1, 1'b1, {NUM_SBOX{8'h4C}});
    step(1'b1, {NUM_SBOX{8'hFF}}, 1'b1, 1'b1, {NUM_SBOX{8'hFF}});
    step(1'b1, {NUM_SBOX{8'h02}}, 1'b1, 1'b1, {NUM_SBOX{8'h6A}});
    drain();

    // all 256 byte values back to back
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < NUM_SBOX; k++) w[8*k +: 8] = 8'(i + 85 * k);
      step(1'b1, w, 1'b1, 1'b0, '0);
    end
    drain();

    // alternating bubbles
    for (int i = 0; i < 40; i++) step((i % 2) == 0, rnd_w(), 1'b1, 1'b0, '0);
    drain();

    // stall with four beats in flight
    lat_mode = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, rnd_w(), 1'b1, 1'b0, '0);
    step(1'b1, rnd_w(), 1'b0, 1'b0, '0);
    snap_bo = bo;
    snap_ov = out_valid;
    chk_eq("stall_ov", 128'(out_valid), 128'(1));
    chk_eq("stall_in_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rnd_w(), 1'b0, 1'b0, '0);
      chk_eq("stall_in_ready", 128'(in_ready), 128'(0));
      chk_eq("stall_ov_hold",  128'(out_valid), 128'(snap_ov));
      chk_eq("stall_bo_hold",  128'(bo), 128'(snap_bo));
    end
    for (int i = 0; i < 3; i++) step(1'b1, rnd_w(), 1'b1, 1'b0, '0);
    drain();

    // same plaintext, two sharings
    lat_mode = 1'b1;
    w = rnd_w();
    step(1'b1, w, 1'b1, 1'b0, '0);
    drain();
    bo_a = last_bo;
    step(1'b1, w, 1'b1, 1'b0, '0);
    drain();
    bo_b = last_bo;
    chk_eq("shares_differ", 128'(bo_a != bo_b), 128'(1));

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) step(1'b1, rnd_w(), 1'b1, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    chk_eq("midrst_bo",        128'(bo),        128'(0));
    chk_eq("midrst_in_ready",  128'(in_ready),  128'(1));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, '0);

    // random traffic with random backpressure
    lat_mode = 1'b0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd_w(), $urandom_range(0, 3) != 0, 1'b0, '0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
